// File: rtl/rv32i_types.sv
// Shared core types: physical-register sizing and free-list pointer types.
package rv32i_types;

  localparam int unsigned PR_NUM   = 64;
  localparam int unsigned RRF_NUM  = 32;
  localparam int unsigned PR_WIDTH = 6;
  localparam int unsigned FL_DEPTH = PR_NUM - RRF_NUM;
  localparam int unsigned FL_IDX_W = $clog2(FL_DEPTH);
  localparam int unsigned FL_PTR_W = FL_IDX_W + 1;

  typedef logic [PR_WIDTH-1:0] preg_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef logic [FL_IDX_W-1:0] fl_idx_t;

endpackage

// File: rtl/free_list_if.sv
// Rename/commit-side connection to the physical-register free list.
interface free_list_if;
  import rv32i_types::*;

  logic    enqueue;
  preg_t   enqueue_index;
  logic    dequeue;
  logic    commit_alloc;
  logic    flush;
  preg_t   free_index;
  logic    empty;
  fl_ptr_t free_count;

  modport master (
    output enqueue, enqueue_index, dequeue, commit_alloc, flush,
    input  free_index, empty, free_count
  );

  modport slave (
    input  enqueue, enqueue_index, dequeue, commit_alloc, flush,
    output free_index, empty, free_count
  );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical registers with a speculative head, a retire
// head for single-cycle mispredict recovery, and a commit-side tail.
module free_list
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  free_list_if.slave  fl
);

  preg_t   mem_q [FL_DEPTH];
  fl_ptr_t head_q, head_d;
  fl_ptr_t rhead_q, rhead_d;
  fl_ptr_t tail_q, tail_d;
  fl_idx_t head_idx, tail_idx;
  logic    empty;
  logic    deq_ok;

  assign head_idx = head_q[FL_IDX_W-1:0];
  assign tail_idx = tail_q[FL_IDX_W-1:0];
  assign empty    = (head_q == tail_q);
  assign deq_ok   = fl.dequeue && !empty;

  // Flush rewinds the speculative head to the retire head, including this cycle's retirement.
  always_comb begin
    rhead_d = rhead_q + fl_ptr_t'(fl.commit_alloc);
    tail_d  = tail_q + fl_ptr_t'(fl.enqueue);
    head_d  = head_q;
    if (fl.flush) begin
      head_d = rhead_d;
    end else if (deq_ok) begin
      head_d = head_q + fl_ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= fl_ptr_t'(FL_DEPTH);
      for (int unsigned i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= preg_t'(RRF_NUM + i);
      end
    end else begin
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      if (fl.enqueue) begin
        mem_q[tail_idx] <= fl.enqueue_index;
      end
    end
  end

  assign fl.free_index = mem_q[head_idx];
  assign fl.empty      = empty;
  assign fl.free_count = tail_q - head_q;

  // Occupancy measured from the retire head bounds both the spec head and the tail.
  fl_ptr_t occ_retire;
  fl_ptr_t occ_spec;
  assign occ_retire = tail_q - rhead_q;
  assign occ_spec   = head_q - rhead_q;

  a_occ_bound: assert property (@(posedge clk) disable iff (rst)
    occ_retire <= fl_ptr_t'(FL_DEPTH))
    else $error("free_list: tail ran more than FL_DEPTH ahead of rhead");

  a_rhead_order: assert property (@(posedge clk) disable iff (rst)
    occ_spec <= occ_retire)
    else $error("free_list: rhead passed head");

  a_enq_nonzero: assert property (@(posedge clk) disable iff (rst)
    !fl.enqueue || (fl.enqueue_index != '0))
    else $error("free_list: physical register 0 returned to free list");

  a_enq_full: assert property (@(posedge clk) disable iff (rst)
    !(fl.enqueue && (occ_retire == fl_ptr_t'(FL_DEPTH))))
    else $error("free_list: enqueue into a full free list");

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios plus randomized traffic checked
// every cycle against an absolute-position queue model.
module tb_free_list;

  logic clk;
  logic rst;
  free_list_if bus ();

  free_list dut (
    .clk (clk),
    .rst (rst),
    .fl  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: unbounded positions; val[p] is the register stored at position p.
  int val [int];
  int m_h, m_r, m_t;
  bit model_valid = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r_, input bit e, input int idx,
                            input bit d, input bit c, input bit f);
    int rn;
    int hn;
    if (r_) begin
      val.delete();
      for (int i = 0; i < 32; i++) val[i] = 32 + i;
      m_h = 0; m_r = 0; m_t = 32;
      model_valid = 1'b1;
    end else begin
      rn = m_r + int'(c);
      hn = m_h;
      if (f) hn = rn;
      else if (d && (m_h != m_t)) hn = m_h + 1;
      if (e) val[m_t] = idx;
      m_t = m_t + int'(e);
      m_r = rn;
      m_h = hn;
    end
  endtask

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("free_count", int'(bus.free_count), m_t - m_h);
      check("empty", int'(bus.empty), int'(m_t == m_h));
      if (m_t != m_h) check("free_index", int'(bus.free_index), val[m_h]);
    end
  end

  task automatic cycle(input bit r_, input bit e, input int idx,
                       input bit d, input bit c, input bit f);
    rst               = r_;
    bus.enqueue       = e;
    bus.enqueue_index = 6'(idx);
    bus.dequeue       = d;
    bus.commit_alloc  = c;
    bus.flush         = f;
    @(posedge clk);
    model_step(r_, e, idx, d, c, f);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int seq [$];
    int v;

    // Reset image
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    check("rst_free_index", int'(bus.free_index), 32);
    check("rst_empty", int'(bus.empty), 0);
    check("rst_free_count", int'(bus.free_count), 32);

    // Drain all 32 in order
    for (int i = 0; i < 32; i++) begin
      check("drain_order", int'(bus.free_index), 32 + i);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    check("drain_empty", int'(bus.empty), 1);
    check("drain_count", int'(bus.free_count), 0);

    // Retire all allocations, then dequeue-while-empty with enqueue of 5
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    check("empty_enq_index", int'(bus.free_index), 5);
    check("empty_enq_count", int'(bus.free_count), 1);
    check("empty_enq_empty", int'(bus.empty), 0);

    // Dequeue 4, retire 1, flush
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("pre_flush_order", int'(bus.free_index), 32 + i);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    check("flush_index", int'(bus.free_index), 33);
    check("flush_count", int'(bus.free_count), 31);

    // Flush + commit + enqueue 7 (+ dropped dequeue) in one cycle
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 7, 1'b1, 1'b1, 1'b1);
    check("fce_index", int'(bus.free_index), 34);
    check("fce_count", int'(bus.free_count), 31);
    for (int i = 0; i < 30; i++) begin
      check("fce_order", int'(bus.free_index), 34 + i);
      cycle(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    check("fce_tail_7", int'(bus.free_index), 7);

    // Recycle across the pointer wrap
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 32; p++) seq.push_back(32 + p);
    cycle(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      check("wrap_order", int'(bus.free_index), seq[1 + k]);
      v = int'(bus.free_index);
      cycle(1'b0, 1'b1, v, 1'b1, 1'b1, 1'b0);
      seq.push_back(v);
      check("wrap_count", int'(bus.free_count), 31);
    end

    // Reset mid-operation
    cycle(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 9 + i, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    check("midrst_index", int'(bus.free_index), 32);
    check("midrst_count", int'(bus.free_count), 32);
    check("midrst_empty", int'(bus.empty), 0);

    // Randomized legal traffic
    for (int n = 0; n < 3000; n++) begin
      bit r_, e, d, c, f;
      int idx;
      r_  = ($urandom_range(0, 199) == 0);
      d   = ($urandom_range(0, 9) < 6);
      c   = (m_r < m_h) && ($urandom_range(0, 1) == 1);
      e   = ((m_t - m_r) < 32) && ($urandom_range(0, 1) == 1);
      f   = ($urandom_range(0, 19) == 0);
      idx = int'($urandom_range(1, 63));
      cycle(r_, e, idx, d, c, f);
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
